hazard_ctrl: RTL and testbench

- Generates the 3-bit forwarding selects and the pipeline stall for the five-stage MIPS core. It is the producer end of the forwarding mux select bus.
- Internally tracks destination, result kind and Tnew for the E/M/W stages, plus the E/M source register numbers.
- Tracks the multiply/divide busy window.
- Sits beside the D stage and is clocked in lockstep with the pipeline registers.

---
 rtl/hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard unit for the five-stage MIPS pipeline: tracks in-flight writers in E/M/W,
// produces forwarding mux selects, the D-stage stall and the HI/LO busy window.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] dst_d,
    input  logic [1:0] kind_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic [2:0] forwardRSD,
    output logic [2:0] forwardRTD,
    output logic [2:0] forwardRSE,
    output logic [2:0] forwardRTE,
    output logic [2:0] forwardRTM,
    output logic       stall,
    output logic       md_busy
);

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_MEM  = 2'd1;
    localparam logic [1:0] KIND_PC8  = 2'd2;
    localparam logic [1:0] KIND_MD   = 2'd3;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [2:0] SEL_RF     = 3'b000;
    localparam logic [2:0] SEL_AO_M   = 3'b001;
    localparam logic [2:0] SEL_RF_WD  = 3'b010;
    localparam logic [2:0] SEL_PC8_E  = 3'b011;
    localparam logic [2:0] SEL_PC8_M  = 3'b100;
    localparam logic [2:0] SEL_PC8_W  = 3'b101;
    localparam logic [2:0] SEL_MD_OUT = 3'b110;
    localparam logic [2:0] SEL_MDO_M  = 3'b111;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    logic [4:0] dst_e_q, dst_e_d, dst_m_q, dst_m_d, dst_w_q, dst_w_d;
    logic [1:0] kind_e_q, kind_e_d, kind_m_q, kind_m_d, kind_w_q, kind_w_d;
    logic [1:0] tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
    logic [4:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, rt_m_q, rt_m_d;
    logic       md_start_e_q, md_start_e_d, md_div_e_q, md_div_e_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       md_busy_s, data_stall_s, stall_s;

    function automatic logic [1:0] tnew_of_kind(input logic [1:0] kind);
        case (kind)
            KIND_ALU: return 2'd1;
            KIND_MEM: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic hit(input logic [4:0] r, input logic [4:0] dst);
        return (r != 5'd0) && (r == dst);
    endfunction

    function automatic logic [2:0] sel_e(input logic [1:0] kind, input logic [1:0] tnew);
        if (tnew != 2'd0) begin
            return SEL_RF;
        end else begin
            case (kind)
                KIND_PC8: return SEL_PC8_E;
                KIND_MD:  return SEL_MD_OUT;
                default:  return SEL_RF;
            endcase
        end
    endfunction

    function automatic logic [2:0] sel_m(input logic [1:0] kind, input logic [1:0] tnew);
        if (tnew != 2'd0) begin
            return SEL_RF;
        end else begin
            case (kind)
                KIND_ALU: return SEL_AO_M;
                KIND_PC8: return SEL_PC8_M;
                KIND_MD:  return SEL_MDO_M;
                default:  return SEL_RF;
            endcase
        end
    endfunction

    function automatic logic [2:0] sel_w(input logic [1:0] kind);
        return (kind == KIND_PC8) ? SEL_PC8_W : SEL_RF_WD;
    endfunction

    // Only the nearest matching stage may supply a value; older copies are stale.
    function automatic logic [2:0] fwd_d_sel(
        input logic [4:0] r,
        input logic [4:0] de, input logic [1:0] ke, input logic [1:0] te,
        input logic [4:0] dm, input logic [1:0] km, input logic [1:0] tm,
        input logic [4:0] dw, input logic [1:0] kw
    );
        if (hit(r, de)) begin
            return sel_e(ke, te);
        end else if (hit(r, dm)) begin
            return sel_m(km, tm);
        end else if (hit(r, dw)) begin
            return sel_w(kw);
        end else begin
            return SEL_RF;
        end
    endfunction

    function automatic logic [2:0] fwd_e_sel(
        input logic [4:0] r,
        input logic [4:0] dm, input logic [1:0] km, input logic [1:0] tm,
        input logic [4:0] dw, input logic [1:0] kw
    );
        if (hit(r, dm)) begin
            return sel_m(km, tm);
        end else if (hit(r, dw)) begin
            return sel_w(kw);
        end else begin
            return SEL_RF;
        end
    endfunction

    function automatic logic op_stall(
        input logic [4:0] r, input logic [1:0] tuse,
        input logic [4:0] de, input logic [1:0] te,
        input logic [4:0] dm, input logic [1:0] tm
    );
        if (tuse == TUSE_NONE) begin
            return 1'b0;
        end else if (hit(r, de)) begin
            return tuse < te;
        end else if (hit(r, dm)) begin
            return tuse < tm;
        end else begin
            return 1'b0;
        end
    endfunction

    // Forward selects, stall and busy from tracked state and the D-stage operands.
    always_comb begin
        md_busy_s    = md_start_e_q | (md_cnt_q != 4'd0);
        data_stall_s = op_stall(rs_d, tuse_rs_d, dst_e_q, tnew_e_q, dst_m_q, tnew_m_q)
                     | op_stall(rt_d, tuse_rt_d, dst_e_q, tnew_e_q, dst_m_q, tnew_m_q);
        stall_s      = data_stall_s | (md_use_d & md_busy_s);
        forwardRSD   = fwd_d_sel(rs_d, dst_e_q, kind_e_q, tnew_e_q,
                                 dst_m_q, kind_m_q, tnew_m_q, dst_w_q, kind_w_q);
        forwardRTD   = fwd_d_sel(rt_d, dst_e_q, kind_e_q, tnew_e_q,
                                 dst_m_q, kind_m_q, tnew_m_q, dst_w_q, kind_w_q);
        forwardRSE   = fwd_e_sel(rs_e_q, dst_m_q, kind_m_q, tnew_m_q, dst_w_q, kind_w_q);
        forwardRTE   = fwd_e_sel(rt_e_q, dst_m_q, kind_m_q, tnew_m_q, dst_w_q, kind_w_q);
        forwardRTM   = hit(rt_m_q, dst_w_q) ? sel_w(kind_w_q) : SEL_RF;
        stall        = stall_s;
        md_busy      = md_busy_s;
    end

    // Pipeline shift of the tracking state; E defaults to a bubble, flush bubbles everything.
    always_comb begin
        dst_e_d      = 5'd0;
        kind_e_d     = KIND_ALU;
        tnew_e_d     = 2'd0;
        rs_e_d       = 5'd0;
        rt_e_d       = 5'd0;
        md_start_e_d = 1'b0;
        md_div_e_d   = 1'b0;
        dst_m_d      = dst_e_q;
        kind_m_d     = kind_e_q;
        tnew_m_d     = tnew_dec(tnew_e_q);
        rt_m_d       = rt_e_q;
        dst_w_d      = dst_m_q;
        kind_w_d     = kind_m_q;
        if (flush) begin
            dst_m_d  = 5'd0;
            kind_m_d = KIND_ALU;
            tnew_m_d = 2'd0;
            rt_m_d   = 5'd0;
            dst_w_d  = 5'd0;
            kind_w_d = KIND_ALU;
        end else if (stall_s) begin
            dst_e_d = 5'd0;
        end else begin
            dst_e_d      = dst_d;
            kind_e_d     = kind_d;
            tnew_e_d     = tnew_of_kind(kind_d);
            rs_e_d       = rs_d;
            rt_e_d       = rt_d;
            md_start_e_d = md_start_d;
            md_div_e_d   = md_start_d & md_div_d;
        end

        if (md_start_e_q) begin
            md_cnt_d = md_div_e_q ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // Tracking state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_e_q      <= 5'd0;
            kind_e_q     <= 2'd0;
            tnew_e_q     <= 2'd0;
            rs_e_q       <= 5'd0;
            rt_e_q       <= 5'd0;
            md_start_e_q <= 1'b0;
            md_div_e_q   <= 1'b0;
            dst_m_q      <= 5'd0;
            kind_m_q     <= 2'd0;
            tnew_m_q     <= 2'd0;
            rt_m_q       <= 5'd0;
            dst_w_q      <= 5'd0;
            kind_w_q     <= 2'd0;
            md_cnt_q     <= 4'd0;
        end else begin
            dst_e_q      <= dst_e_d;
            kind_e_q     <= kind_e_d;
            tnew_e_q     <= tnew_e_d;
            rs_e_q       <= rs_e_d;
            rt_e_q       <= rt_e_d;
            md_start_e_q <= md_start_e_d;
            md_div_e_q   <= md_div_e_d;
            dst_m_q      <= dst_m_d;
            kind_m_q     <= kind_m_d;
            tnew_m_q     <= tnew_m_d;
            rt_m_q       <= rt_m_d;
            dst_w_q      <= dst_w_d;
            kind_w_q     <= kind_w_d;
            md_cnt_q     <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations are hand-derived pipeline timings.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [4:0] rs_d, rt_d, dst_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, kind_d;
    logic       md_start_d, md_div_d, md_use_d;
    logic [2:0] forwardRSD, forwardRTD, forwardRSE, forwardRTE, forwardRTM;
    logic       stall, md_busy;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .tuse_rs_d  (tuse_rs_d),
        .tuse_rt_d  (tuse_rt_d),
        .dst_d      (dst_d),
        .kind_d     (kind_d),
        .md_start_d (md_start_d),
        .md_div_d   (md_div_d),
        .md_use_d   (md_use_d),
        .forwardRSD (forwardRSD),
        .forwardRTD (forwardRTD),
        .forwardRSE (forwardRSE),
        .forwardRTE (forwardRTE),
        .forwardRTM (forwardRTM),
        .stall      (stall),
        .md_busy    (md_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] urs, input logic [1:0] urt,
                         input logic [4:0] dst, input logic [1:0] kind,
                         input logic ms, input logic mdiv, input logic muse);
        rs_d = rs; rt_d = rt; tuse_rs_d = urs; tuse_rt_d = urt;
        dst_d = dst; kind_d = kind;
        md_start_d = ms; md_div_d = mdiv; md_use_d = muse;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0;
        set_d(5'd3, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        settle();
        total++; if (forwardRSD !== 3'b000) begin bad++; $display("FAIL reset_fRSD got=%b exp=000", forwardRSD); end
        total++; if (forwardRTD !== 3'b000) begin bad++; $display("FAIL reset_fRTD got=%b exp=000", forwardRTD); end
        total++; if (forwardRSE !== 3'b000) begin bad++; $display("FAIL reset_fRSE got=%b exp=000", forwardRSE); end
        total++; if (forwardRTE !== 3'b000) begin bad++; $display("FAIL reset_fRTE got=%b exp=000", forwardRTE); end
        total++; if (forwardRTM !== 3'b000) begin bad++; $display("FAIL reset_fRTM got=%b exp=000", forwardRTM); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
        tick();
        reset = 1'b1;
        drain();
    endtask

    task automatic test_reset_midstream();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);   // div
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL div_issue_stall got=%b exp=0", stall); end
        tick();
        nop(); tick(); tick(); tick();                                   // counter: 10, 9, 8
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd2, 1'b0, 1'b0, 1'b0);   // jal
        tick();                                                          // counter 7, jal in E
        set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // jr $31
        settle();
        total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b exp=1", md_busy); end
        total++; if (forwardRSD !== 3'b011) begin bad++; $display("FAIL mid_fRSD_pre got=%b exp=011", forwardRSD); end
        reset = 1'b0;
        #1;
        total++; if (forwardRSD !== 3'b000) begin bad++; $display("FAIL mid_fRSD_rst got=%b exp=000", forwardRSD); end
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_rst got=%b exp=0", md_busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_stall_rst got=%b exp=0", stall); end
        tick();
        reset = 1'b1;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);   // mflo-like HI/LO user
        settle();
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_post got=%b exp=0", md_busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_stall_post got=%b exp=0", stall); end
        tick();
        drain();
    endtask

    task automatic test_alu_branch();
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd0, 1'b0, 1'b0, 1'b0);   // addu $3
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_issue_stall got=%b exp=0", stall); end
        tick();
        set_d(5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // beq $3
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL alu_br_stall got=%b exp=1", stall); end
        total++; if (forwardRSD !== 3'b000) begin bad++; $display("FAIL alu_br_fRSD0 got=%b exp=000", forwardRSD); end
        tick();
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_br_unstall got=%b exp=0", stall); end
        total++; if (forwardRSD !== 3'b001) begin bad++; $display("FAIL alu_br_fRSD got=%b exp=001", forwardRSD); end
        tick();
        drain();
    endtask

    task automatic test_load_use();
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);   // lw $5
        tick();
        set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd6, 2'd0, 1'b0, 1'b0, 1'b0);   // addu rs=$5
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
        tick();
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_unstall got=%b exp=0", stall); end
        total++; if (forwardRSD !== 3'b000) begin bad++; $display("FAIL lu_fRSD got=%b exp=000", forwardRSD); end
        tick();
        nop();
        settle();
        total++; if (forwardRSE !== 3'b010) begin bad++; $display("FAIL lu_fRSE got=%b exp=010", forwardRSE); end
        tick();
        drain();
    endtask

    task automatic test_jal_jr();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd2, 1'b0, 1'b0, 1'b0);  // jal
        tick();
        set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);  // jr $31
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL jr_stall got=%b exp=0", stall); end
        total++; if (forwardRSD !== 3'b011) begin bad++; $display("FAIL jr_fRSD got=%b exp=011", forwardRSD); end
        tick();
        nop();
        settle();
        total++; if (forwardRSE !== 3'b100) begin bad++; $display("FAIL jr_fRSE got=%b exp=100", forwardRSE); end
        tick();
        drain();
    endtask

    task automatic test_mult_mflo();
        int stalls;
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);   // mult
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd3, 1'b0, 1'b0, 1'b1);   // mflo $8
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (stall === 1'b1) stalls++;
            tick();
        end
        total++; if (stalls != 6) begin bad++; $display("FAIL md_stall_count got=%0d exp=6", stalls); end
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL md_unstall got=%b exp=0", stall); end
        total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL md_busy_end got=%b exp=0", md_busy); end
        tick();
        set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0);   // addu rs=$8
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL md_cons_stall got=%b exp=0", stall); end
        total++; if (forwardRSD !== 3'b110) begin bad++; $display("FAIL md_fRSD got=%b exp=110", forwardRSD); end
        tick();
        nop();
        settle();
        total++; if (forwardRSE !== 3'b111) begin bad++; $display("FAIL md_fRSE got=%b exp=111", forwardRSE); end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0);   // jal-like writer of $4
        tick();
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);   // addu $4
        tick();
        set_d(5'd4, 5'd0, 2'd1, 2'd3, 5'd10, 2'd0, 1'b0, 1'b0, 1'b0);  // reader of $4
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", stall); end
        total++; if (forwardRSD !== 3'b000) begin bad++; $display("FAIL b2b_fRSD got=%b exp=000", forwardRSD); end
        tick();
        nop();
        settle();
        total++; if (forwardRSE !== 3'b001) begin bad++; $display("FAIL b2b_fRSE got=%b exp=001", forwardRSE); end
        tick();
        drain();
    endtask

    task automatic test_zero_reg();
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);   // load to $0
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // reads $0 early
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b exp=0", stall); end
        total++; if (forwardRSD !== 3'b000) begin bad++; $display("FAIL zero_fRSD got=%b exp=000", forwardRSD); end
        total++; if (forwardRTD !== 3'b000) begin bad++; $display("FAIL zero_fRTD got=%b exp=000", forwardRTD); end
        tick();
        drain();
    endtask

    task automatic test_flush_stall();
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);   // lw $5
        tick();
        set_d(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // beq $5
        settle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fl_stall_pre got=%b exp=1", stall); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall_post got=%b exp=0", stall); end
        total++; if (forwardRSD !== 3'b000) begin bad++; $display("FAIL fl_fRSD got=%b exp=000", forwardRSD); end
        tick();
        drain();
    endtask

    task automatic test_store_rtm();
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);   // lw $7
        tick();
        set_d(5'd2, 5'd7, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);   // sw $7
        settle();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL st_stall got=%b exp=0", stall); end
        tick();
        nop();
        settle();
        total++; if (forwardRTE !== 3'b000) begin bad++; $display("FAIL st_fRTE got=%b exp=000", forwardRTE); end
        tick();
        settle();
        total++; if (forwardRTM !== 3'b010) begin bad++; $display("FAIL st_fRTM got=%b exp=010", forwardRTM); end
        tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_alu_branch();
        test_load_use();
        test_jal_jr();
        test_mult_mflo();
        test_back_to_back();
        test_zero_reg();
        test_flush_stall();
        test_store_rtm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
